rename_free_list: RTL and testbench
===================================

# rename_free_list

Physical-register free list for the rename stage of the N-way superscalar out-of-order RISC-V core. It tracks which of the N_ROB+32 physical registers are free. Each cycle it offers up to N_WAY free tags to dispatch, lowest index first. It reclaims the stale tags (Told) that the ROB releases at retirement.

## Interface
Parameters (from the shared package):
- N_WAY, 3, dispatch/retire width
- N_ROB, 32, ROB entries; physical register count N_PHYS = N_ROB+32
- CDB_BITS, $clog2(N_PHYS), physical tag width

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- rob_told  in  N_WAY×CDB_BITS  tags released by retiring ROB entries; tag 0 means "no release" in that slot
- dispatched  in  N_WAY  per-way dispatch valid mask
- dispatch_num  in  $clog2(N_WAY)+1  number of instructions dispatched this cycle
- free_list_out  out  N_WAY×CDB_BITS  offered free tags, slot 0 = lowest free index
- free_num  out  $clog2(N_WAY)+1  number of valid slots in free_list_out, min(N_WAY, free count)
- free  out  N_PHYS  debug: bit p = 1 when physical register p is free

## Operation
- State is the free bit-vector `free[N_PHYS-1:0]`. Nothing else is stored.
- Reset: bits 0..31 = 0, because they hold the initial architectural mapping. Bits 32..N_PHYS-1 = 1.
- Selection is combinational from the current `free`:
  - free_list_out[k] = index of the (k+1)-th lowest set bit.
  - Slots k ≥ free_num output 0.
- Allocation: way i allocates free_list_out[i] when all three hold:
  - i < dispatch_num
  - dispatched[i] = 1
  - i < free_num

  The allocated bit is cleared at the next edge.
- Release: every rob_told[i] ≠ 0 sets free[rob_told[i]] at the next edge.
  - Tag 0 is never released.
  - Releasing an already-free tag is harmless; the bit stays 1.
- Simultaneous allocate and release in one cycle are both applied. If the same tag is targeted by both, release wins. This cannot occur legally.
- dispatch_num > free_num: the excess ways are ignored and no invalid tag is allocated. Upstream must stall on free_num.
- No bypass: a tag released this cycle is offered no earlier than the next cycle.

## Timing
- free_list_out, free_num and free are combinational from registered state. They are valid within the same cycle after reset.
- Reset values (N_WAY=3, N_ROB=32):
  - free_list_out = {32,33,34}
  - free_num = 3
  - free = 64'hFFFF_FFFF_0000_0000
- Allocation and release latency: 1 cycle; visible on outputs after the edge.
- Reset asserted mid-operation restores the reset map at the next edge, discarding all allocations and releases.
- Empty (no free bits): free_num = 0 and all free_list_out slots = 0.
- Full: after all non-architectural tags are released, free_num = N_WAY again.

## Structure
- Shared package holds N_WAY, N_ROB, N_PHYS, CDB_BITS and the reserved-tag constant ZERO_TAG = 0.
- One sub-module, `free_reg_selector`: a parameterized priority picker returning the N_WAY lowest set bits of a vector, plus their count.
- The top module holds the free register and the allocate/release update logic.

## Test plan
- Reset, then hold dispatch_num=0 → free_list_out={32,33,34}, free_num=3, free[31:0]=0, free[63:32]=all ones.
- dispatch_num=3, dispatched=3'b111 for 10 cycles → free_list_out={62,63,0}, free_num=2. One more cycle with dispatch_num=2 → free_num=0, free=0.
- With the list empty, release rob_told={1,2,3} for one cycle → next cycle free_list_out={1,2,3}, free_num=3.
- rob_told={0,0,0} with dispatch_num=0 → free unchanged, confirming tag 0 is never freed.
- From reset, dispatch_num=3, dispatched=3'b011 → only 32 and 33 allocated; next cycle free_list_out={34,35,36}.
- Same cycle: dispatch_num=1 and rob_told={13,14,15}, with 13–15 allocated and 32 free → 32 allocated and 13,14,15 freed. Next cycle free_list_out={13,14,15}.
- Reset asserted mid-run → next cycle outputs equal the reset values.

Source files
------------

// File: rtl/rename_free_list_pkg.sv
// Shared parameters and tag types for the rename-stage physical register free list.
//   N_WAY     : dispatch / retire width
//   N_ROB     : ROB entries; physical registers beyond the architectural set
//   N_PHYS    : total physical registers (N_ROB + N_ARCH)
//   CDB_BITS  : physical tag width
//   CNT_BITS  : width of slot counts (0..N_WAY)
//   ZERO_TAG  : reserved tag meaning "no release"
package rename_free_list_pkg;

  localparam int unsigned N_WAY    = 3;
  localparam int unsigned N_ROB    = 32;
  localparam int unsigned N_ARCH   = 32;
  localparam int unsigned N_PHYS   = N_ROB + N_ARCH;
  localparam int unsigned CDB_BITS = $clog2(N_PHYS);
  localparam int unsigned CNT_BITS = $clog2(N_WAY) + 1;

  typedef logic [CDB_BITS-1:0] tag_t;
  typedef tag_t [N_WAY-1:0]    tag_vec_t;

  localparam tag_t ZERO_TAG = '0;

  // Architectural registers hold the initial mapping; everything above is free.
  localparam logic [N_PHYS-1:0] RESET_FREE = {{N_ROB{1'b1}}, {N_ARCH{1'b0}}};

endpackage : rename_free_list_pkg

// File: rtl/free_reg_selector.sv
// Priority picker: returns the indices of the PICKS lowest set bits of vec,
// lowest first, plus how many were found. Unused slots read as 0.
//   vec   : candidate bit-vector
//   tags  : picked indices, slot 0 = lowest
//   count : number of valid slots, min(PICKS, popcount(vec))
module free_reg_selector #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned PICKS = 3,
  parameter int unsigned TAG_W = 6,
  parameter int unsigned CNT_W = 3
) (
  input  logic [WIDTH-1:0]            vec,
  output logic [PICKS-1:0][TAG_W-1:0] tags,
  output logic [CNT_W-1:0]            count
);

  logic [WIDTH-1:0] rem;
  logic             found;
  logic [TAG_W-1:0] idx;

  // Repeatedly take the lowest remaining bit and strike it out.
  always_comb begin
    rem   = vec;
    tags  = '0;
    count = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < PICKS; k++) begin
      found = 1'b0;
      idx   = '0;
      for (int p = 0; p < WIDTH; p++) begin
        if (!found && rem[p]) begin
          found = 1'b1;
          idx   = TAG_W'(p);
        end
      end
      if (found) begin
        tags[k]  = idx;
        rem[idx] = 1'b0;
        count    = count + CNT_W'(1);
      end
    end
  end

endmodule : free_reg_selector

// File: rtl/rename_free_list.sv
// Physical register free list for the rename stage.
// Holds one free bit per physical register, offers the N_WAY lowest free tags
// to dispatch each cycle, and reclaims stale tags released at retirement.
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   rob_told      : per-slot released tag, ZERO_TAG = no release
//   dispatched    : per-way dispatch valid mask
//   dispatch_num  : number of instructions dispatched this cycle
//   free_list_out : offered free tags, slot 0 = lowest index
//   free_num      : valid slots in free_list_out
//   free          : current free bit-vector (debug)
module rename_free_list
  import rename_free_list_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  tag_vec_t            rob_told,
  input  logic [N_WAY-1:0]    dispatched,
  input  logic [CNT_BITS-1:0] dispatch_num,
  output tag_vec_t            free_list_out,
  output logic [CNT_BITS-1:0] free_num,
  output logic [N_PHYS-1:0]   free
);

  logic [N_PHYS-1:0] free_q;
  logic [N_PHYS-1:0] free_d;
  logic [N_WAY-1:0]  alloc_c;

  // Offer the lowest free tags straight from the registered state.
  free_reg_selector #(
    .WIDTH (N_PHYS),
    .PICKS (N_WAY),
    .TAG_W (CDB_BITS),
    .CNT_W (CNT_BITS)
  ) u_selector (
    .vec   (free_q),
    .tags  (free_list_out),
    .count (free_num)
  );

  // A way allocates only when it is dispatching and its offered slot is valid,
  // so excess ways beyond free_num never consume a tag.
  always_comb begin
    alloc_c = '0;
    for (int i = 0; i < N_WAY; i++) begin
      alloc_c[i] = (CNT_BITS'(i) < dispatch_num) && dispatched[i] &&
                   (CNT_BITS'(i) < free_num);
    end
  end

  // Clear allocations first, then apply releases so release wins on a clash.
  always_comb begin
    free_d = free_q;
    for (int i = 0; i < N_WAY; i++) begin
      if (alloc_c[i]) begin
        free_d[free_list_out[i]] = 1'b0;
      end
    end
    for (int i = 0; i < N_WAY; i++) begin
      if (rob_told[i] != ZERO_TAG) begin
        free_d[rob_told[i]] = 1'b1;
      end
    end
  end

  // Free bit-vector state.
  always_ff @(posedge clock) begin
    if (reset) begin
      free_q <= RESET_FREE;
    end else begin
      free_q <= free_d;
    end
  end

  assign free = free_q;

endmodule : rename_free_list

// File: tb/tb_rename_free_list.sv
// Scoreboard bench for rename_free_list: the driver pushes the expected visible
// state for each cycle, a monitor on the falling edge pops and compares.
module tb_rename_free_list;
  import rename_free_list_pkg::*;

  logic                clock;
  logic                reset;
  tag_vec_t            rob_told;
  logic [N_WAY-1:0]    dispatched;
  logic [CNT_BITS-1:0] dispatch_num;
  tag_vec_t            free_list_out;
  logic [CNT_BITS-1:0] free_num;
  logic [N_PHYS-1:0]   free;

  rename_free_list dut (
    .clock         (clock),
    .reset         (reset),
    .rob_told      (rob_told),
    .dispatched    (dispatched),
    .dispatch_num  (dispatch_num),
    .free_list_out (free_list_out),
    .free_num      (free_num),
    .free          (free)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [5:0]  t0;
    logic [5:0]  t1;
    logic [5:0]  t2;
    logic [2:0]  num;
    logic [63:0] fr;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [63:0] RM = 64'hFFFF_FFFF_0000_0000;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Monitor: outputs are always presented; compare one expectation per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.name, ".slot0"}, 64'(free_list_out[0]), 64'(e.t0));
        chk({e.name, ".slot1"}, 64'(free_list_out[1]), 64'(e.t1));
        chk({e.name, ".slot2"}, 64'(free_list_out[2]), 64'(e.t2));
        chk({e.name, ".num"},   64'(free_num),         64'(e.num));
        chk({e.name, ".free"},  free,                  e.fr);
      end
    end
  end

  // One cycle: record what the current state must show, then drive new inputs.
  task automatic step(input logic rst, input logic [2:0] dn, input logic [2:0] dm,
                      input logic [5:0] r0, input logic [5:0] r1, input logic [5:0] r2,
                      input string nm, input logic [5:0] e0, input logic [5:0] e1,
                      input logic [5:0] e2, input logic [2:0] en, input logic [63:0] ef);
    exp_t e;
    @(posedge clock);
    #1;
    e.name = nm; e.t0 = e0; e.t1 = e1; e.t2 = e2; e.num = en; e.fr = ef;
    q.push_back(e);
    reset        = rst;
    dispatch_num = dn;
    dispatched   = dm;
    rob_told[0]  = r0;
    rob_told[1]  = r1;
    rob_told[2]  = r2;
  endtask

  initial begin
    reset        = 1'b1;
    rob_told     = '0;
    dispatched   = '0;
    dispatch_num = '0;
    repeat (2) @(posedge clock);

    step(0, 0, 0, 0, 0, 0, "reset", 32, 33, 34, 3, RM);
    for (int k = 0; k < 10; k++) begin
      step(0, 3, 3'b111, 0, 0, 0, "drain", 6'(32 + 3*k), 6'(33 + 3*k), 6'(34 + 3*k), 3,
           {64{1'b1}} << (32 + 3*k));
    end
    step(0, 2, 3'b111, 0, 0, 0, "two_left", 62, 63, 0, 2, 64'hC000_0000_0000_0000);
    step(0, 0, 0, 1, 2, 3, "empty", 0, 0, 0, 0, 64'h0);
    step(0, 0, 0, 0, 0, 0, "released", 1, 2, 3, 3, 64'hE);
    step(0, 2, 3'b011, 0, 0, 0, "tag0_kept", 1, 2, 3, 3, 64'hE);
    step(0, 3, 3'b111, 0, 0, 0, "one_left", 3, 0, 0, 1, 64'h8);
    step(1, 0, 0, 0, 0, 0, "excess", 0, 0, 0, 0, 64'h0);
    step(0, 3, 3'b011, 0, 0, 0, "mid_reset", 32, 33, 34, 3, RM);
    step(1, 0, 0, 0, 0, 0, "partial_mask", 34, 35, 36, 3, 64'hFFFF_FFFC_0000_0000);
    step(0, 1, 3'b001, 13, 14, 15, "reset2", 32, 33, 34, 3, RM);
    step(0, 0, 0, 32, 40, 0, "alloc_release", 13, 14, 15, 3, 64'hFFFF_FFFE_0000_E000);
    step(0, 0, 0, 0, 0, 0, "rerelease", 13, 14, 15, 3, 64'hFFFF_FFFF_0000_E000);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clock);
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout pending=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rename_free_list
